// File: rtl/master_nios2_qsys_0_oci_dct_pkg.sv
// Shared constants and state encoding for the OCI trace packer.
//   SYM_WIDTH : width of one trace symbol
//   MAX_COUNT : symbols per full frame
//   DCT_WIDTH : packed frame width (SYM_WIDTH * MAX_COUNT)
//   CNT_WIDTH : width of the frame symbol count
package master_nios2_qsys_0_oci_dct_pkg;

  localparam int SYM_WIDTH = 2;
  localparam int MAX_COUNT = 15;
  localparam int DCT_WIDTH = SYM_WIDTH * MAX_COUNT;
  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_ENDED = 2'd2
  } dct_state_e;

endpackage

// File: rtl/master_nios2_qsys_0_oci_dct_packer_if.sv
// Symbol input, frame output and end-of-test status of the trace packer.
//   master : traffic source / frame sink (drives symbols, flush, end_req, dct_ready)
//   slave  : the packer itself
interface master_nios2_qsys_0_oci_dct_packer_if;
  import master_nios2_qsys_0_oci_dct_pkg::*;

  logic                 sym_valid;
  logic [SYM_WIDTH-1:0] sym_data;
  logic                 sym_ready;
  logic                 flush;
  logic                 end_req;
  logic [DCT_WIDTH-1:0] dct_buffer;
  logic [CNT_WIDTH-1:0] dct_count;
  logic                 dct_valid;
  logic                 dct_ready;
  logic                 test_ending;
  logic                 test_has_ended;

  modport master (
    output sym_valid, sym_data, flush, end_req, dct_ready,
    input  sym_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
  );

  modport slave (
    input  sym_valid, sym_data, flush, end_req, dct_ready,
    output sym_ready, dct_buffer, dct_count, dct_valid, test_ending, test_has_ended
  );
endinterface

// File: rtl/master_nios2_qsys_0_oci_dct_outreg.sv
// Output frame register with valid/ready hold.
//   load/load_data/load_count : capture a closed frame (only when out_free)
//   out_ready                 : downstream acceptance
//   out_valid/out_data/out_count : offered frame, stable until accepted
//   out_free                  : register can take a frame on this edge
module master_nios2_qsys_0_oci_dct_outreg
  import master_nios2_qsys_0_oci_dct_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [DCT_WIDTH-1:0] load_data,
  input  logic [CNT_WIDTH-1:0] load_count,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [DCT_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0] out_count,
  output logic                 out_free
);
  logic                 valid_reg;
  logic [DCT_WIDTH-1:0] data_reg;
  logic [CNT_WIDTH-1:0] count_reg;

  // Free when empty, or when the current frame leaves on this same edge.
  assign out_free = !valid_reg || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      count_reg <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      count_reg <= load_count;
    end else if (valid_reg && out_ready) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      count_reg <= '0;
    end
  end

  assign out_valid = valid_reg;
  assign out_data  = data_reg;
  assign out_count = count_reg;
endmodule

// File: rtl/master_nios2_qsys_0_oci_dct_packer.sv
// Packs 2-bit trace symbols into 15-symbol frames and hands them downstream.
//   clk, reset : sole clock, asynchronous active-high reset
//   bus        : symbol input, flush/end_req pulses, frame output, test status
// A fill register assembles symbols; a closed fill moves straight into the
// output register on the closing edge when that register is free, otherwise it
// waits (closed) and stalls the symbol input.
module master_nios2_qsys_0_oci_dct_packer
  import master_nios2_qsys_0_oci_dct_pkg::*;
(
  input logic                                 clk,
  input logic                                 reset,
  master_nios2_qsys_0_oci_dct_packer_if.slave bus
);
  dct_state_e           state_reg, state_next;
  logic [DCT_WIDTH-1:0] fill_data_reg, fill_data_next;
  logic [CNT_WIDTH-1:0] fill_n_reg, fill_n_next;
  logic                 fill_closed_reg, fill_closed_next;

  logic                 sym_ready_int;
  logic                 accept;
  logic [DCT_WIDTH-1:0] merged_data;
  logic [CNT_WIDTH-1:0] merged_n;
  logic                 close_req;
  logic                 close_now;
  logic                 load;
  logic                 out_valid;
  logic                 out_free;
  logic [DCT_WIDTH-1:0] out_data;
  logic [CNT_WIDTH-1:0] out_count;

  // Held low during reset so every output reads zero while reset is high.
  assign sym_ready_int = (state_reg == ST_RUN) && !fill_closed_reg && !reset;
  assign accept        = bus.sym_valid && sym_ready_int;
  assign merged_n      = fill_n_reg + CNT_WIDTH'(accept);

  // Fill contents including this cycle's symbol, written into its slot.
  genvar gi;
  generate
    for (gi = 0; gi < MAX_COUNT; gi++) begin : g_slot
      assign merged_data[gi*SYM_WIDTH +: SYM_WIDTH] =
        (accept && fill_n_reg == CNT_WIDTH'(gi)) ? bus.sym_data
                                                 : fill_data_reg[gi*SYM_WIDTH +: SYM_WIDTH];
    end
  endgenerate

  // end_req in RUN closes a partial fill exactly like flush does.
  assign close_req = bus.flush || (state_reg == ST_RUN && bus.end_req);
  assign close_now = fill_closed_reg
                  || (merged_n == CNT_WIDTH'(MAX_COUNT))
                  || (close_req && merged_n != '0);
  assign load      = close_now && out_free;

  always_comb begin
    fill_data_next   = merged_data;
    fill_n_next      = merged_n;
    fill_closed_next = 1'b0;
    if (load) begin
      fill_data_next = '0;
      fill_n_next    = '0;
    end else if (close_now) begin
      fill_closed_next = 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_RUN:   if (bus.end_req) state_next = ST_DRAIN;
      // Fill is never written in DRAIN, so an empty fill plus a free output
      // register means the last frame leaves on this edge.
      ST_DRAIN: if (fill_n_reg == '0 && out_free) state_next = ST_ENDED;
      ST_ENDED: state_next = ST_ENDED;
      default:  state_next = ST_RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_RUN;
      fill_data_reg   <= '0;
      fill_n_reg      <= '0;
      fill_closed_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      fill_data_reg   <= fill_data_next;
      fill_n_reg      <= fill_n_next;
      fill_closed_reg <= fill_closed_next;
    end
  end

  master_nios2_qsys_0_oci_dct_outreg u_outreg (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (merged_data),
    .load_count (merged_n),
    .out_ready  (bus.dct_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_count  (out_count),
    .out_free   (out_free)
  );

  assign bus.sym_ready      = sym_ready_int;
  assign bus.dct_valid      = out_valid;
  assign bus.dct_buffer     = out_data;
  assign bus.dct_count      = out_count;
  assign bus.test_ending    = (state_reg != ST_RUN);
  assign bus.test_has_ended = (state_reg == ST_ENDED);
endmodule

// File: tb/tb_master_nios2_qsys_0_oci_dct_packer.sv
// Bench for the trace packer: directed scenarios plus random traffic, checked
// every cycle against a frame-level reference model (queue of expected frames,
// two-frame storage capacity, RUN/DRAIN/ENDED status).
module tb_master_nios2_qsys_0_oci_dct_packer;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  master_nios2_qsys_0_oci_dct_packer_if bus ();

  master_nios2_qsys_0_oci_dct_packer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [29:0] data;
    logic [3:0]  count;
  } frame_t;

  typedef enum int { M_RUN, M_DRAIN, M_ENDED } mstate_e;

  int          total = 0;
  int          bad = 0;
  int          frames_out = 0;
  frame_t      m_q[$];
  logic [29:0] m_part_data = '0;
  int          m_part_n = 0;
  mstate_e     m_state = M_RUN;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: evaluated mid-cycle with inputs stable, then advanced
  // to represent the state after the coming rising edge.
  always @(negedge clk) begin
    logic    exp_ready;
    logic    close;
    mstate_e nxt;
    frame_t  f;
    if (reset) begin
      m_q.delete();
      m_part_data = '0;
      m_part_n    = 0;
      m_state     = M_RUN;
    end else begin
      exp_ready = (m_state == M_RUN) && (m_q.size() < 2);
      check("sym_ready", 32'(bus.sym_ready), 32'(exp_ready));
      check("dct_valid", 32'(bus.dct_valid), 32'(m_q.size() != 0));
      if (m_q.size() != 0) begin
        check("dct_buffer", 32'(bus.dct_buffer), 32'(m_q[0].data));
        check("dct_count", 32'(bus.dct_count), 32'(m_q[0].count));
      end
      check("test_ending", 32'(bus.test_ending), 32'(m_state != M_RUN));
      check("test_has_ended", 32'(bus.test_has_ended), 32'(m_state == M_ENDED));

      if (m_q.size() != 0 && bus.dct_ready) begin
        f = m_q.pop_front();
        frames_out++;
        $display("frame %0d: count=%0d data=%08h", frames_out, f.count, f.data);
      end
      if (bus.sym_valid && exp_ready) begin
        m_part_data[2*m_part_n +: 2] = bus.sym_data;
        m_part_n++;
      end
      close = (m_part_n == 15)
           || ((bus.flush || (m_state == M_RUN && bus.end_req)) && m_part_n != 0);
      if (close) begin
        f.data  = m_part_data;
        f.count = 4'(m_part_n);
        m_q.push_back(f);
        m_part_data = '0;
        m_part_n    = 0;
      end
      nxt = m_state;
      if (m_state == M_RUN && bus.end_req) nxt = M_DRAIN;
      if (m_state == M_DRAIN && m_q.size() == 0) nxt = M_ENDED;
      m_state = nxt;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [29:0] exp_pat;
    int          base;
    int          n;
    bus.sym_valid = 1'b0;
    bus.sym_data  = '0;
    bus.flush     = 1'b0;
    bus.end_req   = 1'b0;
    bus.dct_ready = 1'b1;

    // Reset state.
    step();
    check("rst_dct_valid", 32'(bus.dct_valid), 32'd0);
    check("rst_sym_ready_during", 32'(bus.sym_ready), 32'd0);
    step();
    reset = 1'b0;
    #1;
    check("rst_sym_ready_after", 32'(bus.sym_ready), 32'd1);
    check("rst_dct_buffer", 32'(bus.dct_buffer), 32'd0);
    check("rst_dct_count", 32'(bus.dct_count), 32'd0);
    check("rst_test_ending", 32'(bus.test_ending), 32'd0);

    // Full frame of 0,1,2,3,0,... back to back.
    exp_pat = '0;
    for (int i = 0; i < 15; i++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'(i % 4);
      exp_pat[2*i +: 2] = 2'(i % 4);
      step();
    end
    bus.sym_valid = 1'b0;
    check("full_valid_latency", 32'(bus.dct_valid), 32'd1);
    check("full_count", 32'(bus.dct_count), 32'd15);
    check("full_buffer", 32'(bus.dct_buffer), 32'(exp_pat));
    step();
    check("full_consumed", 32'(bus.dct_valid), 32'd0);

    // Three symbols of 3 then flush.
    for (int i = 0; i < 3; i++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'd3;
      step();
    end
    bus.sym_valid = 1'b0;
    bus.flush     = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush_count", 32'(bus.dct_count), 32'd3);
    check("flush_buffer", 32'(bus.dct_buffer), 32'h0000003F);
    step();

    // Backpressure: 30 symbols fill both registers.
    bus.dct_ready = 1'b0;
    for (int i = 0; i < 30; i++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'($urandom_range(0, 3));
      step();
    end
    for (int i = 0; i < 3; i++) begin
      check("bp_sym_ready_low", 32'(bus.sym_ready), 32'd0);
      step();
    end
    bus.sym_valid = 1'b0;
    base = frames_out;
    bus.dct_ready = 1'b1;
    step();
    step();
    step();
    check("bp_two_frames", 32'(frames_out - base), 32'd2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      bus.sym_valid = ($urandom_range(0, 3) != 0);
      bus.sym_data  = 2'($urandom_range(0, 3));
      bus.flush     = ($urandom_range(0, 9) == 0);
      bus.dct_ready = ($urandom_range(0, 2) != 0);
      step();
    end
    bus.sym_valid = 1'b0;
    bus.flush     = 1'b1;
    bus.dct_ready = 1'b1;
    step();
    bus.flush = 1'b0;
    n = 0;
    while (bus.dct_valid && n < 10) begin
      step();
      n++;
    end
    check("drain_timeout", 32'(bus.dct_valid), 32'd0);

    // Five symbols then end_req.
    bus.dct_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'($urandom_range(0, 3));
      step();
    end
    bus.sym_valid = 1'b0;
    bus.end_req   = 1'b1;
    step();
    bus.end_req = 1'b0;
    check("end_test_ending", 32'(bus.test_ending), 32'd1);
    check("end_sym_ready", 32'(bus.sym_ready), 32'd0);
    check("end_count", 32'(bus.dct_count), 32'd5);
    check("end_not_ended_yet", 32'(bus.test_has_ended), 32'd0);
    step();
    bus.dct_ready = 1'b1;
    step();
    check("end_has_ended", 32'(bus.test_has_ended), 32'd1);
    check("end_valid_low", 32'(bus.dct_valid), 32'd0);
    bus.end_req = 1'b1;
    step();
    bus.end_req = 1'b0;
    step();
    check("end_sticky", 32'(bus.test_has_ended), 32'd1);

    // Reset with a frame offered and 7 symbols in the fill.
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.dct_ready = 1'b0;
    for (int i = 0; i < 22; i++) begin
      bus.sym_valid = 1'b1;
      bus.sym_data  = 2'($urandom_range(1, 3));
      step();
    end
    bus.sym_valid = 1'b0;
    check("pre_rst_valid", 32'(bus.dct_valid), 32'd1);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.dct_valid), 32'd0);
    check("mid_rst_buffer", 32'(bus.dct_buffer), 32'd0);
    check("mid_rst_count", 32'(bus.dct_count), 32'd0);
    check("mid_rst_sym_ready", 32'(bus.sym_ready), 32'd0);
    check("mid_rst_has_ended", 32'(bus.test_has_ended), 32'd0);
    step();
    step();
    reset = 1'b0;
    bus.dct_ready = 1'b1;
    base = frames_out;
    for (int i = 0; i < 20; i++) step();
    check("no_stale_frame", 32'(frames_out - base), 32'd0);

    // Flush and end_req with nothing stored.
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("empty_flush_no_frame", 32'(bus.dct_valid), 32'd0);
    bus.end_req = 1'b1;
    step();
    bus.end_req = 1'b0;
    check("empty_end_ending", 32'(bus.test_ending), 32'd1);
    check("empty_end_not_yet", 32'(bus.test_has_ended), 32'd0);
    step();
    check("empty_end_ended", 32'(bus.test_has_ended), 32'd1);
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
